// File: rtl/i2c_write_engine.sv
// i2c_write_engine: bit-level I2C master issuing one 3-byte write
// (device addr, reg addr, reg data) per start pulse. SCLK is push-pull,
// SDAT is open-drain (driven 0 or released).
// Optional feature macro: I2C_AUTO_RETRY_EN -- after a NACK, wait a
// 4-quarter bus-idle gap and resend the latched word, up to MAX_RETRY times.
module i2c_write_engine #(
  parameter int CLK_DIV   = 125,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] i2c_data,
  input  logic        start,
  output logic        done,
  output logic        ack,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;
`ifdef I2C_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_FINISH, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shift_q, shift_d;
  logic [23:0]   word_q, word_d;
  logic [AW-1:0] att_q, att_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          sclk_q, sclk_d;
  logic          sda_low_q, sda_low_d;
  logic          tick;
  logic          sda_in;
  logic          retry;

  assign tick     = (div_q == DW'(CLK_DIV - 1));
  assign sda_in   = i2c_sdat;
  assign retry    = RETRY_EN && nack_q && (att_q < AW'(MAX_RETRY));
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
  assign i2c_sclk = sclk_q;
  assign done     = done_q;
  assign ack      = ack_q;

  // Next-state, quarter sequencing, and pin levels for the upcoming quarter
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    word_d  = word_q;
    att_d   = att_q;
    nack_d  = nack_q;
    done_d  = done_q;
    ack_d   = ack_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (start) begin
          state_d = S_START;
          qtr_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          shift_d = i2c_data;
          word_d  = i2c_data;
          att_d   = '0;
          nack_d  = 1'b0;
          done_d  = 1'b0;
          ack_d   = 1'b0;
        end
      end
      S_START: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd1) begin
          state_d = S_BIT;
          qtr_d   = '0;
        end
      end
      S_BIT: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          shift_d = {shift_q[22:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        // SCL has been high for a full quarter here; a released line is NACK
        if (qtr_q == 2'd2 && sda_in) nack_d = 1'b1;
        if (qtr_q == 2'd3) begin
          if (nack_q || byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BIT;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      S_STOP: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd2) begin
          qtr_d   = '0;
          state_d = retry ? S_GAP : S_FINISH;
        end
      end
      S_GAP: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          state_d = S_START;
          bit_d   = '0;
          byte_d  = '0;
          shift_d = word_q;
          nack_d  = 1'b0;
          att_d   = att_q + AW'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        ack_d   = ~nack_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin levels follow the state/quarter being entered
    sclk_d    = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: begin
        sclk_d    = (qtr_d == 2'd0);
        sda_low_d = 1'b1;
      end
      S_BIT: begin
        sclk_d    = qtr_d[1];
        sda_low_d = ~shift_d[23];
      end
      S_ACK:   sclk_d = qtr_d[1];
      S_STOP: begin
        sclk_d    = (qtr_d != 2'd0);
        sda_low_d = (qtr_d != 2'd2);
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset aborts without a STOP
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      att_q     <= '0;
      nack_q    <= 1'b0;
      done_q    <= 1'b1;
      ack_q     <= 1'b0;
      sclk_q    <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      att_q     <= att_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      sclk_q    <= sclk_d;
      sda_low_q <= sda_low_d;
    end
  end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: quarter-level bus model, bus decoder with a
// scriptable ACK/NACK slave, per-cycle comparison of SCL/SDA/done.
module tb_i2c_write_engine;

  localparam int D = 4;
`ifdef I2C_AUTO_RETRY_EN
  localparam int EFF_RETRY = 3;
`else
  localparam int EFF_RETRY = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] i2c_data = '0;
  logic        start = 1'b0;
  logic        done, ack, i2c_sclk;
  wire         sda_w;
  logic        slave_low = 1'b0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  i2c_write_engine #(.CLK_DIV(D), .MAX_RETRY(3)) dut (
    .clk(clk), .reset_n(reset_n), .i2c_data(i2c_data), .start(start),
    .done(done), .ack(ack), .i2c_sclk(i2c_sclk), .i2c_sdat(sda_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected per-quarter bus levels and decoded bytes
  logic       exp_scl[$];
  logic       exp_sda[$];
  logic [7:0] exp_bytes[$];

  // bus decoder + slave
  int         dec_starts = 0, dec_stops = 0, dec_rises = 0;
  logic [7:0] dec_bytes[$];
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         bitpos = 0, byte_idx = 0, att_idx = 0;
  logic [7:0] sh = '0;
  int         nack_first_n = 0;
  int         txn_base = 0;

  always @(negedge clk) begin
    logic s, d;
    s = i2c_sclk;
    d = sda_w;
    if (p_scl && s && p_sda && !d) begin
      dec_starts <= dec_starts + 1;
      att_idx    <= dec_starts - txn_base;
      bitpos     <= 0;
      byte_idx   <= 0;
      slave_low  <= 1'b0;
    end else if (p_scl && s && !p_sda && d) begin
      dec_stops <= dec_stops + 1;
      bitpos    <= 0;
      slave_low <= 1'b0;
    end else if (!p_scl && s) begin
      dec_rises <= dec_rises + 1;
      if (bitpos < 8) begin
        sh     <= {sh[6:0], d};
        bitpos <= bitpos + 1;
        if (bitpos == 7) dec_bytes.push_back({sh[6:0], d});
      end else if (bitpos == 8) begin
        bitpos <= 9;
      end
    end else if (p_scl && !s) begin
      if (bitpos == 8) begin
        slave_low <= !(byte_idx == 0 && att_idx < nack_first_n);
      end else if (bitpos == 9) begin
        slave_low <= 1'b0;
        bitpos    <= 0;
        byte_idx  <= byte_idx + 1;
      end
    end
    p_scl <= s;
    p_sda <= d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic push_q(input logic c, input logic s);
    exp_scl.push_back(c);
    exp_sda.push_back(s);
  endtask

  task automatic push_slot(input logic s);
    push_q(1'b0, s); push_q(1'b0, s); push_q(1'b1, s); push_q(1'b1, s);
  endtask

  // Bus-level model: START, 9-clock byte slots, STOP, optional idle gap + resend
  task automatic build_model(input logic [23:0] w, input int nackn, input int maxr,
                             output int len, output int attempts, output logic ok,
                             output int rises);
    logic [7:0] by;
    logic nk;
    exp_scl.delete(); exp_sda.delete(); exp_bytes.delete();
    attempts = 0; ok = 1'b0; rises = 0;
    for (int a = 0; a <= maxr; a++) begin
      nk = (a < nackn);
      attempts++;
      push_q(1'b1, 1'b0); push_q(1'b0, 1'b0);
      for (int b = 0; b < 3; b++) begin
        by = w[23 - 8*b -: 8];
        exp_bytes.push_back(by);
        for (int i = 7; i >= 0; i--) push_slot(by[i]);
        push_slot((b == 0) && nk);
        rises += 9;
        if ((b == 0) && nk) break;
      end
      push_q(1'b0, 1'b0); push_q(1'b1, 1'b0); push_q(1'b1, 1'b1);
      rises += 1;
      if (!nk) begin
        ok = 1'b1;
        break;
      end
      if (a < maxr) repeat (4) push_q(1'b1, 1'b1);
    end
    len = exp_scl.size();
  endtask

  // Per-cycle comparison of outputs against the quarter model
  task automatic cycle_compare(input int m, input int len);
    int q;
    logic es, ed;
    q  = m / D;
    es = 1'b1;
    ed = 1'b1;
    if (q < len) begin
      es = exp_scl[q];
      ed = exp_sda[q];
    end
    chk($sformatf("scl@%0d", m), i2c_sclk, es);
    if (m % D == 2) chk($sformatf("sda@%0d", m), sda_w, ed);
    if (m <= len * D) chk($sformatf("done_low@%0d", m), done, 1'b0);
  endtask

  task automatic run_txn(input logic [23:0] word, input int nackn, input int poke_at,
                         input string nm);
    int len, attempts, rises, t0, m, s0, p0, r0, b0, nb;
    logic ok, got;
    build_model(word, nackn, EFF_RETRY, len, attempts, ok, rises);
    @(negedge clk);
    nack_first_n = nackn;
    txn_base = dec_starts;
    s0 = dec_starts; p0 = dec_stops; r0 = dec_rises; b0 = dec_bytes.size();
    i2c_data = word;
    start = 1'b1;
    t0 = cyc + 1;
    got = 1'b0;
    m = 0;
    for (int k = 0; k < len * D + 20; k++) begin
      @(negedge clk);
      m = cyc - t0;
      cycle_compare(m, len);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      start = (m == poke_at);
      i2c_data = (m == poke_at) ? 24'hFFFFFF : ~word;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, got, 1'b1);
    chk_rng({nm, "_done_latency"}, m, len * D + 1, len * D + 3);
    chk({nm, "_ack"}, ack, ok);
    chk({nm, "_starts"}, dec_starts - s0, attempts);
    chk({nm, "_stops"}, dec_stops - p0, attempts);
    chk({nm, "_rises"}, dec_rises - r0, rises);
    nb = dec_bytes.size() - b0;
    chk({nm, "_nbytes"}, nb, exp_bytes.size());
    for (int i = 0; i < nb && i < exp_bytes.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), dec_bytes[b0 + i], exp_bytes[i]);
    // done/ack hold in idle, bus stays quiet
    repeat (6) begin
      @(negedge clk);
      chk({nm, "_idle_scl"}, i2c_sclk, 1'b1);
      chk({nm, "_idle_done"}, done, 1'b1);
      chk({nm, "_idle_ack"}, ack, ok);
    end
    chk({nm, "_no_extra_scl"}, dec_rises - r0, rises);
  endtask

  initial begin
    int len, att, rs, t0;
    logic ok;

    // reset with start held high: nothing may launch
    start = 1'b1;
    i2c_data = 24'h340C10;
    repeat (3) @(negedge clk);
    chk("rst_scl", i2c_sclk, 1'b1);
    chk("rst_sda", sda_w, 1'b1);
    chk("rst_done", done, 1'b1);
    chk("rst_ack", ack, 1'b0);
    start = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_done", done, 1'b1);
      chk("post_rst_scl", i2c_sclk, 1'b1);
    end

    // literal pins on the model
    build_model(24'h340C10, 0, 0, len, att, ok, rs);
    chk("pin_full_len", len, 113);
    chk("pin_full_rises", rs, 28);
    chk("pin_full_b0", exp_bytes[0], 8'h34);
    chk("pin_full_b1", exp_bytes[1], 8'h0C);
    chk("pin_full_b2", exp_bytes[2], 8'h10);
    build_model(24'h340C10, 1000, 0, len, att, ok, rs);
    chk("pin_nack_len", len, 41);
    chk("pin_nack_ok", ok, 1'b0);
    build_model(24'h340C10, 2, 3, len, att, ok, rs);
    chk("pin_retry_len", len, 203);
    chk("pin_retry_att", att, 3);
    build_model(24'h340C10, 1000, 3, len, att, ok, rs);
    chk("pin_always_nack_len", len, 176);
    chk("pin_always_nack_att", att, 4);

    run_txn(24'h340C10, 0, -1, "full");
    run_txn(24'h340C10, 1000, -1, "nack_addr");
    run_txn(24'hA5FF00, 0, -1, "pattern");
    // second start with other data in the middle of byte 2 must be ignored
    run_txn(24'h1A2B3C, 0, (2 + 36 + 16) * D, "busy_start");

    // reset pulse in byte 2 (bit 3, SCL low quarter)
    @(negedge clk);
    nack_first_n = 0;
    txn_base = dec_starts;
    i2c_data = 24'h340C10;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400 && (cyc - t0) < (2 + 36 + 13) * D; k++) @(negedge clk);
    chk("pre_abort_done", done, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_scl", i2c_sclk, 1'b1);
    chk("abort_sda", sda_w, 1'b1);
    chk("abort_done", done, 1'b1);
    chk("abort_ack", ack, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_scl", i2c_sclk, 1'b1);
      chk("abort_idle_done", done, 1'b1);
    end
    run_txn(24'h340C10, 0, -1, "after_abort");

`ifdef I2C_AUTO_RETRY_EN
    run_txn(24'h340C10, 2, -1, "retry_ok");
    run_txn(24'h340C10, 1000, -1, "retry_fail");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
